sf_camera_capture: RTL and testbench

//  Parametrised single-clock frame capture engine for the sf_camera family.

---
 rtl/sf_camera_capture_if.sv | 40 ++++
 rtl/sf_camera_capture.sv | 174 +++++++++++++++++
 tb/tb_sf_camera_capture.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sf_camera_capture_if.sv
// Camera capture bus: synchronised pixel bus, control/status and FIFO read port.
// master drives the camera/control/read-strobe side, slave is the capture engine.
interface sf_camera_capture_if #(
  parameter int unsigned PIXEL_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH_LOG2 = 10,
  parameter int unsigned COUNT_WIDTH     = 32
);
  logic                     i_enable;
  logic                     i_continuous;
  logic                     i_reset_counts;
  logic                     i_vsync;
  logic                     i_hsync;
  logic                     i_pix_valid;
  logic [PIXEL_WIDTH-1:0]   i_pix_data;
  logic                     o_busy;
  logic                     o_captured;
  logic                     o_overflow;
  logic [COUNT_WIDTH-1:0]   o_row_count;
  logic [COUNT_WIDTH-1:0]   o_pixel_count;
  logic [COUNT_WIDTH-1:0]   o_frame_count;
  logic                     i_rd_strobe;
  logic [DATA_WIDTH-1:0]    o_rd_data;
  logic                     o_rd_empty;
  logic [FIFO_DEPTH_LOG2:0] o_fifo_count;

  modport master (
    output i_enable, i_continuous, i_reset_counts, i_vsync, i_hsync,
           i_pix_valid, i_pix_data, i_rd_strobe,
    input  o_busy, o_captured, o_overflow, o_row_count, o_pixel_count,
           o_frame_count, o_rd_data, o_rd_empty, o_fifo_count
  );

  modport slave (
    input  i_enable, i_continuous, i_reset_counts, i_vsync, i_hsync,
           i_pix_valid, i_pix_data, i_rd_strobe,
    output o_busy, o_captured, o_overflow, o_row_count, o_pixel_count,
           o_frame_count, o_rd_data, o_rd_empty, o_fifo_count
  );
endinterface

// File: rtl/sf_camera_capture.sv
// Frame capture engine: packs sampled pixels into words and buffers them in a
// first-word-fall-through FIFO, with frame/row/pixel counters and sticky overflow.
module sf_camera_capture #(
  parameter int unsigned PIXEL_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH_LOG2 = 10,
  parameter int unsigned COUNT_WIDTH     = 32
) (
  input logic            clk,
  input logic            rst,
  sf_camera_capture_if.slave bus
);
  localparam int unsigned PPW   = DATA_WIDTH / PIXEL_WIDTH;
  localparam int unsigned IDX_W = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_W = FIFO_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_VSYNC = 2'd1, CAPTURE = 2'd2, DONE = 2'd3} state_t;
  state_t state, state_next;

  logic vsync_q, hsync_q;
  logic vs_rise, vs_fall, hs_fall;
  logic capturing, take, row_end, frame_end, frame_start;

  assign vs_rise     = bus.i_vsync & ~vsync_q;
  assign vs_fall     = ~bus.i_vsync & vsync_q;
  assign hs_fall     = ~bus.i_hsync & hsync_q;
  assign capturing   = (state == CAPTURE) & bus.i_enable;
  assign take        = capturing & bus.i_pix_valid & bus.i_hsync & bus.i_vsync;
  assign row_end     = capturing & hs_fall;
  assign frame_end   = capturing & vs_fall;
  assign frame_start = (state == WAIT_VSYNC) & vs_rise & bus.i_enable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q <= 1'b0;
      hsync_q <= 1'b0;
    end else begin
      vsync_q <= bus.i_vsync;
      hsync_q <= bus.i_hsync;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Dropping enable aborts from any state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (bus.i_enable) state_next = WAIT_VSYNC;
      WAIT_VSYNC: if (vs_rise) state_next = CAPTURE;
      CAPTURE:    if (vs_fall) state_next = bus.i_continuous ? WAIT_VSYNC : DONE;
      default:    ;
    endcase
    if (!bus.i_enable) state_next = IDLE;
  end

  // Packer: slot pack_idx receives the incoming pixel, lowest slot first
  logic [IDX_W-1:0]      pack_idx;
  logic [DATA_WIDTH-1:0] pack_data, pack_next;
  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;

  always_comb begin
    pack_next = pack_data;
    for (int unsigned s = 0; s < PPW; s++) begin
      if (pack_idx == IDX_W'(s)) pack_next[s*PIXEL_WIDTH +: PIXEL_WIDTH] = bus.i_pix_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pack_idx  <= '0;
      pack_data <= '0;
      wr_valid  <= 1'b0;
      wr_data   <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (!bus.i_enable) begin
        pack_idx  <= '0;
        pack_data <= '0;
      end else if (take) begin
        if (pack_idx == IDX_W'(PPW - 1)) begin
          wr_valid  <= 1'b1;
          wr_data   <= pack_next;
          pack_idx  <= '0;
          pack_data <= '0;
        end else begin
          pack_idx  <= pack_idx + IDX_W'(1);
          pack_data <= pack_next;
        end
      end else if ((row_end || frame_end) && pack_idx != '0) begin
        wr_valid  <= 1'b1;
        wr_data   <= pack_data;
        pack_idx  <= '0;
        pack_data <= '0;
      end
    end
  end

  // FIFO
  logic [DATA_WIDTH-1:0]      mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]           count;
  logic                       pop, full, push;

  assign pop  = bus.i_rd_strobe & (count != '0);
  assign full = (count == CNT_W'(DEPTH));
  assign push = wr_valid & (~full | pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + FIFO_DEPTH_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Counters and status; a count clear wins over a same-cycle increment
  logic [COUNT_WIDTH-1:0] row_pix, row_count, pixel_count, frame_count;
  logic                   captured, overflow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_pix     <= '0;
      row_count   <= '0;
      pixel_count <= '0;
      frame_count <= '0;
      captured    <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      captured <= frame_end;
      if (row_end || frame_start || !bus.i_enable) row_pix <= '0;
      else if (take)                               row_pix <= row_pix + COUNT_WIDTH'(1);
      if (bus.i_reset_counts) begin
        row_count   <= '0;
        pixel_count <= '0;
        frame_count <= '0;
        overflow    <= 1'b0;
      end else begin
        if (frame_start)  row_count <= '0;
        else if (row_end) row_count <= row_count + COUNT_WIDTH'(1);
        if (row_end)      pixel_count <= row_pix;
        if (frame_end)    frame_count <= frame_count + COUNT_WIDTH'(1);
        if (wr_valid && !push) overflow <= 1'b1;
      end
    end
  end

  assign bus.o_busy        = (state == CAPTURE);
  assign bus.o_captured    = captured;
  assign bus.o_overflow    = overflow;
  assign bus.o_row_count   = row_count;
  assign bus.o_pixel_count = pixel_count;
  assign bus.o_frame_count = frame_count;
  assign bus.o_rd_empty    = (count == '0);
  assign bus.o_rd_data     = (count == '0) ? '0 : mem[rd_ptr];
  assign bus.o_fifo_count  = count;
endmodule

// File: tb/tb_sf_camera_capture.sv
// Bench for sf_camera_capture: random and directed frames, scoreboard on the
// FIFO read side, counters compared against a frame-level model.
module tb_sf_camera_capture;
  localparam int unsigned PW  = 8;
  localparam int unsigned DW  = 32;
  localparam int unsigned FDL = 2;
  localparam int unsigned CW  = 16;

  typedef logic [7:0] pix_q_t [$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sf_camera_capture_if #(.PIXEL_WIDTH(PW), .DATA_WIDTH(DW), .FIFO_DEPTH_LOG2(FDL), .COUNT_WIDTH(CW)) bus ();

  sf_camera_capture #(.PIXEL_WIDTH(PW), .DATA_WIDTH(DW), .FIFO_DEPTH_LOG2(FDL), .COUNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int m_rows = 0, m_lastpix = 0, m_frames = 0, m_pulses = 0, cap_pulses = 0;
  bit rd_en = 1'b0, manual_strobe = 1'b0, use_model = 1'b1;
  logic [31:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Read-side monitor: pops whenever enabled and a word is presented
  initial begin
    bus.i_rd_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_en && !bus.o_rd_empty) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", bus.o_rd_data);
        end else begin
          check("rd_data", 64'(bus.o_rd_data), 64'(exp_q.pop_front()));
        end
        bus.i_rd_strobe = 1'b1;
      end else begin
        bus.i_rd_strobe = manual_strobe;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_captured === 1'b1) cap_pulses++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  // Reference packing: 4 pixels per word, first pixel in the low byte, zero padded
  function automatic void model_row(input pix_q_t pix);
    int n;
    logic [31:0] word;
    n = pix.size();
    for (int w = 0; w * 4 < n; w++) begin
      word = '0;
      for (int k = 0; k < 4; k++) if (w * 4 + k < n) word[k*8 +: 8] = pix[w*4+k];
      exp_q.push_back(word);
    end
  endfunction

  task automatic frame_begin(input bit cap);
    bus.i_vsync = 1'b1;
    tick;
    tick;
    if (cap) m_rows = 0;
  endtask

  task automatic drive_row(input pix_q_t pix, input bit cap, input bit sim);
    if (cap && use_model) model_row(pix);
    bus.i_hsync = 1'b1;
    tick;
    foreach (pix[i]) begin
      bus.i_pix_valid = 1'b1;
      bus.i_pix_data  = pix[i];
      tick;
      bus.i_pix_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick;
    end
    bus.i_hsync = 1'b0;
    if (sim) bus.i_vsync = 1'b0;
    tick;
    if (cap) begin
      m_rows++;
      m_lastpix = pix.size();
      if (sim) begin
        m_frames++;
        m_pulses++;
      end
    end
    repeat (2) tick;
  endtask

  task automatic frame_end(input bit cap, input bit sim);
    if (!sim) begin
      bus.i_vsync = 1'b0;
      tick;
      if (cap) begin
        m_frames++;
        m_pulses++;
      end
    end
    repeat (2) tick;
  endtask

  task automatic random_frame;
    int nrows;
    bit sim;
    pix_q_t p;
    nrows = $urandom_range(1, 4);
    frame_begin(1'b1);
    sim = 1'b0;
    for (int r = 0; r < nrows; r++) begin
      p = {};
      repeat ($urandom_range(0, 12)) p.push_back(8'($urandom_range(0, 255)));
      sim = (r == nrows - 1) && ($urandom_range(0, 1) == 1);
      drive_row(p, 1'b1, sim);
    end
    frame_end(1'b1, sim);
  endtask

  task automatic drain;
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && bus.o_rd_empty) break;
      tick;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    check("drain_empty", 64'(bus.o_rd_empty), 64'd1);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_row_count"}, 64'(bus.o_row_count), 64'(m_rows));
    check({tag, "_pixel_count"}, 64'(bus.o_pixel_count), 64'(m_lastpix));
    check({tag, "_frame_count"}, 64'(bus.o_frame_count), 64'(m_frames));
    check({tag, "_captured_pulses"}, 64'(cap_pulses), 64'(m_pulses));
    check({tag, "_overflow"}, 64'(bus.o_overflow), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, 64'(bus.o_busy), 64'd0);
    check({tag, "_captured"}, 64'(bus.o_captured), 64'd0);
    check({tag, "_overflow"}, 64'(bus.o_overflow), 64'd0);
    check({tag, "_row_count"}, 64'(bus.o_row_count), 64'd0);
    check({tag, "_pixel_count"}, 64'(bus.o_pixel_count), 64'd0);
    check({tag, "_frame_count"}, 64'(bus.o_frame_count), 64'd0);
    check({tag, "_rd_empty"}, 64'(bus.o_rd_empty), 64'd1);
    check({tag, "_fifo_count"}, 64'(bus.o_fifo_count), 64'd0);
    check({tag, "_rd_data"}, 64'(bus.o_rd_data), 64'd0);
  endtask

  task automatic arm;
    bus.i_enable = 1'b1;
    tick;
    tick;
  endtask

  task automatic disarm;
    bus.i_enable = 1'b0;
    tick;
  endtask

  initial begin
    pix_q_t p;
    rst = 1'b0;
    bus.i_enable = 1'b0; bus.i_continuous = 1'b0; bus.i_reset_counts = 1'b0;
    bus.i_vsync = 1'b0; bus.i_hsync = 1'b0; bus.i_pix_valid = 1'b0; bus.i_pix_data = '0;
    repeat (3) tick;
    check_reset_state("reset");
    rst = 1'b1;
    rd_en = 1'b1;
    tick;

    // 2 rows x 8 px, single shot
    use_model = 1'b0;
    exp_q.push_back(32'h03020100); exp_q.push_back(32'h07060504);
    exp_q.push_back(32'h0B0A0908); exp_q.push_back(32'h0F0E0D0C);
    arm;
    frame_begin(1'b1);
    for (int r = 0; r < 2; r++) begin
      p = {};
      for (int i = 0; i < 8; i++) p.push_back(8'(r * 8 + i));
      drive_row(p, 1'b1, 1'b0);
    end
    frame_end(1'b1, 1'b0);
    drain;
    check("t1_row_count", 64'(bus.o_row_count), 64'd2);
    check("t1_pixel_count", 64'(bus.o_pixel_count), 64'd8);
    check("t1_captured_pulses", 64'(cap_pulses), 64'd1);
    check("t1_busy_done", 64'(bus.o_busy), 64'd0);
    check_counts("t1");
    disarm;

    // 5 px row with hsync and vsync falling together
    exp_q.push_back(32'h14131211); exp_q.push_back(32'h00000015);
    arm;
    frame_begin(1'b1);
    p = {};
    for (int i = 0; i < 5; i++) p.push_back(8'(8'h11 + i));
    drive_row(p, 1'b1, 1'b1);
    frame_end(1'b1, 1'b1);
    drain;
    check("t2_pixel_count", 64'(bus.o_pixel_count), 64'd5);
    check("t2_row_count", 64'(bus.o_row_count), 64'd1);
    check_counts("t2");
    disarm;

    // random single-shot frames
    use_model = 1'b1;
    for (int f = 0; f < 6; f++) begin
      arm;
      random_frame;
      drain;
      check_counts("rand");
      disarm;
    end

    // overflow with no reads
    rd_en = 1'b0;
    tick;
    arm;
    frame_begin(1'b1);
    p = {};
    for (int i = 0; i < 24; i++) p.push_back(8'($urandom_range(0, 255)));
    drive_row(p, 1'b1, 1'b0);
    while (exp_q.size() > 4) void'(exp_q.pop_back());
    frame_end(1'b1, 1'b0);
    check("ovf_fifo_count", 64'(bus.o_fifo_count), 64'd4);
    check("ovf_flag", 64'(bus.o_overflow), 64'd1);
    bus.i_reset_counts = 1'b1;
    tick;
    bus.i_reset_counts = 1'b0;
    m_rows = 0; m_lastpix = 0; m_frames = 0;
    check("ovf_cleared", 64'(bus.o_overflow), 64'd0);
    check("ovf_fifo_kept", 64'(bus.o_fifo_count), 64'd4);
    check_counts("rstcnt");
    rd_en = 1'b1;
    drain;
    disarm;

    // enable mid-frame: that frame must be ignored
    bus.i_vsync = 1'b1;
    tick; tick;
    bus.i_hsync = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) bus.i_enable = 1'b1;
      bus.i_pix_valid = 1'b1;
      bus.i_pix_data  = 8'(8'hA0 + i);
      tick;
    end
    bus.i_pix_valid = 1'b0;
    bus.i_hsync = 1'b0;
    tick;
    bus.i_vsync = 1'b0;
    repeat (3) tick;
    check("midframe_busy", 64'(bus.o_busy), 64'd0);
    check("midframe_fifo", 64'(bus.o_fifo_count), 64'd0);
    check_counts("midframe");

    // continuous mode over 3 frames
    bus.i_continuous = 1'b1;
    for (int f = 0; f < 3; f++) begin
      random_frame;
      check("cont_busy_gap", 64'(bus.o_busy), 64'd0);
      drain;
      check_counts("cont");
    end
    check("cont_frame_count", 64'(bus.o_frame_count), 64'd3);
    bus.i_continuous = 1'b0;
    disarm;

    // abort mid-row after 3 px
    arm;
    frame_begin(1'b1);
    bus.i_hsync = 1'b1;
    tick;
    for (int i = 0; i < 3; i++) begin
      bus.i_pix_valid = 1'b1;
      bus.i_pix_data  = 8'(8'hC0 + i);
      tick;
    end
    bus.i_pix_valid = 1'b0;
    bus.i_enable = 1'b0;
    tick;
    check("abort_busy", 64'(bus.o_busy), 64'd0);
    bus.i_hsync = 1'b0;
    tick;
    bus.i_vsync = 1'b0;
    repeat (5) tick;
    check("abort_fifo", 64'(bus.o_fifo_count), 64'd0);
    check_counts("abort");

    // asynchronous reset mid-frame
    rd_en = 1'b0;
    tick;
    arm;
    frame_begin(1'b0);
    bus.i_hsync = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.i_pix_valid = 1'b1;
      bus.i_pix_data  = 8'(8'hE0 + i);
      tick;
    end
    bus.i_pix_valid = 1'b0;
    tick;
    check("prerst_fifo", 64'(bus.o_fifo_count), 64'd1);
    check("prerst_busy", 64'(bus.o_busy), 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    bus.i_enable = 1'b0; bus.i_hsync = 1'b0; bus.i_vsync = 1'b0;
    #1;
    check_reset_state("midrst");
    exp_q.delete();
    tick; tick;
    rst = 1'b1;
    tick;
    manual_strobe = 1'b1;
    tick;
    manual_strobe = 1'b0;
    tick;
    check("empty_pop_count", 64'(bus.o_fifo_count), 64'd0);
    check("empty_pop_empty", 64'(bus.o_rd_empty), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
